// File: rtl/grid_load_sequencer.sv
// rtl/grid_load_sequencer.sv - loads a 9x9 puzzle from ROM into the grid, then arbitrates engine writes
//
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   puzzle_sel, load_req   puzzle index and single-cycle reload request (honoured in READY only)
//   rom_addr, rom_val      puzzle ROM address out, cell value back one cycle later
//   user_req/row/col/val   engine single-cell write request
//   user_gnt               same-cycle grant for user_req
//   wr_en/row/col/val      grid write port
//   wr_fixed               fixed-mask bit written with the cell
//   ready, load_done       grid open for user writes / one-cycle pulse when a load completes
module grid_load_sequencer #(
  parameter int NUM_PUZZLES = 3,
  parameter int CELLS       = 81
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] puzzle_sel,
  input  logic       load_req,
  output logic [7:0] rom_addr,
  input  logic [3:0] rom_val,
  input  logic       user_req,
  input  logic [3:0] user_row,
  input  logic [3:0] user_col,
  input  logic [3:0] user_val,
  output logic       user_gnt,
  output logic       wr_en,
  output logic [3:0] wr_row,
  output logic [3:0] wr_col,
  output logic [3:0] wr_val,
  output logic       wr_fixed,
  output logic       ready,
  output logic       load_done
);

  typedef enum logic [1:0] {START, LOAD, DRAIN, READY} state_t;

  localparam logic [6:0] LAST_IDX = 7'(CELLS - 1);
  localparam logic [7:0] CELLS_W  = 8'(CELLS);

  state_t     state_q, state_d;
  logic       latch_sel;
  logic [1:0] sel_q;
  logic [1:0] sel_mapped;
  logic [6:0] idx_q;
  logic [3:0] row_q, col_q;
  logic       p_valid_q;
  logic [3:0] p_row_q, p_col_q;
  logic       done_q;
  logic [3:0] clean_val;

  // Out-of-range puzzle indices fall back to puzzle 0 so the ROM address never overflows.
  assign sel_mapped = (32'(puzzle_sel) < NUM_PUZZLES) ? puzzle_sel : 2'd0;

  always_comb begin
    state_d   = state_q;
    latch_sel = 1'b0;
    case (state_q)
      START: begin
        state_d   = LOAD;
        latch_sel = 1'b1;
      end
      LOAD: begin
        if (idx_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = READY;
      end
      READY: begin
        if (load_req) begin
          state_d   = LOAD;
          latch_sel = 1'b1;
        end
      end
      default: state_d = START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= START;
      sel_q     <= 2'd0;
      idx_q     <= 7'd0;
      row_q     <= 4'd0;
      col_q     <= 4'd0;
      p_valid_q <= 1'b0;
      p_row_q   <= 4'd0;
      p_col_q   <= 4'd0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_sel) sel_q <= sel_mapped;

      // Counters only run in LOAD; they sit at zero otherwise so every load starts at cell 0.
      if (state_q == LOAD && idx_q != LAST_IDX) begin
        idx_q <= idx_q + 7'd1;
        if (col_q == 4'd8) begin
          col_q <= 4'd0;
          row_q <= row_q + 4'd1;
        end else begin
          col_q <= col_q + 4'd1;
        end
      end else begin
        idx_q <= 7'd0;
        row_q <= 4'd0;
        col_q <= 4'd0;
      end

      // One-stage pipeline aligns the cell coordinates with the ROM's one-cycle read latency.
      p_valid_q <= (state_q == LOAD);
      p_row_q   <= row_q;
      p_col_q   <= col_q;

      // DRAIN is always followed by READY, so this marks the first READY cycle.
      done_q <= (state_q == DRAIN);
    end
  end

  assign rom_addr  = 8'(sel_q) * CELLS_W + 8'(idx_q);
  assign ready     = (state_q == READY);
  assign load_done = done_q;
  assign user_gnt  = user_req && (state_q == READY) && !load_req;

  // Corrupt ROM entries above 9 are written as blank, non-fixed cells.
  assign clean_val = (rom_val > 4'd9) ? 4'd0 : rom_val;

  // Load writes and user grants never overlap: the pipeline is only valid in LOAD/DRAIN,
  // grants only happen in READY.
  always_comb begin
    wr_en    = 1'b0;
    wr_row   = p_row_q;
    wr_col   = p_col_q;
    wr_val   = clean_val;
    wr_fixed = 1'b0;
    if (p_valid_q) begin
      wr_en    = 1'b1;
      wr_fixed = (clean_val != 4'd0);
    end else if (user_gnt) begin
      wr_row = user_row;
      wr_col = user_col;
      wr_val = user_val;
      // Off-grid targets are acknowledged but dropped.
      wr_en  = (user_row <= 4'd8) && (user_col <= 4'd8);
    end
  end

endmodule
